// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. Computes {c,s} = a + b + cin one bit per
//   clock, LSB first, using a single shared 1-bit full adder. A request is
//   accepted in IDLE when start is high. WIDTH clock edges later the result
//   is loaded into s/c and done pulses for one cycle. The FSM then returns
//   to IDLE one edge after that. With start held high, one operation is
//   accepted every WIDTH+2 cycles.
//
//   Optional feature: define SERIAL_ADD_OVF_EN to add the signed overflow
//   output ovf. When the macro is undefined, the port and its logic are absent.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   request a new addition (sampled only in IDLE)
//   a,b   in   WIDTH-bit operands, captured on acceptance
//   cin   in   carry-in, captured on acceptance
//   busy  out  high while an operation is running or completing
//   done  out  one-cycle pulse, result valid
//   s     out  WIDTH-bit sum register
//   c     out  carry-out register
//   ovf   out  signed overflow register (SERIAL_ADD_OVF_EN only)

// 1-bit full adder; the controller instantiates exactly one of these.
module serial_add_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic sum,
   output logic co
);
   assign sum = x ^ y ^ ci;
   assign co  = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the WIDTH-1 sum bits produced before the final edge; the final
   // sum bit is concatenated on top when s is loaded.
   logic [WIDTH-2:0] acc;
   logic [WIDTH-1:0] acc_shift;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_sum;
   logic             fa_co;
   logic             accept;
   logic             last_bit;

   serial_add_fa u_fa (
      .x   (a_sh[0]),
      .y   (b_sh[0]),
      .ci  (carry),
      .sum (fa_sum),
      .co  (fa_co)
   );

   assign accept    = (state == ST_IDLE) && start;
   assign last_bit  = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));
   assign acc_shift = {fa_sum, acc};
   assign busy      = (state != ST_IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start)    state_nxt = ST_RUN;
         ST_RUN:  if (last_bit) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         c     <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= last_bit;
         if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_shift[WIDTH-1:1];
            carry <= fa_co;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
               s <= acc_shift;
               c <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
               // carry flop holds the carry into the MSB on this edge
               ovf <= carry ^ fa_co;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         c;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .c     (c)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: true sum of the operands as plain integers.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      int unsigned t;
      t = int'(x) + int'(y) + int'(ci);
      return t[W:0];
   endfunction

   // Reference: signed result outside the W-bit two's complement range.
   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci);
      int sx, sy, t;
      sx = int'(x);
      sy = int'(y);
      if (x[W-1]) sx = sx - (1 << W);
      if (y[W-1]) sy = sy - (1 << W);
      t = sx + sy + int'(ci);
      return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
   endfunction

   // Runs one operation from IDLE. lat is the number of edges after the
   // accepting edge at which done was first seen (-1 on timeout).
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input bit disturb, output int lat, output bit s_moved,
                         output bit busy_low);
      logic [W-1:0] s_before;
      int guard;
      guard = 0;
      while (busy && guard < 4) begin
         @(posedge clk); #1;
         guard++;
      end
      s_before = s;
      a = ta; b = tb_; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = disturb;
      lat = -1; s_moved = 0; busy_low = 0;
      for (int k = 1; k <= 2 * W + 4; k++) begin
         if (disturb) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         end
         @(posedge clk); #1;
         if (!busy) busy_low = 1;
         if (done) begin
            lat = k;
            break;
         end
         if (s !== s_before) s_moved = 1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #2;
      n_checks++;
      if ({busy, done, s, c} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b s=%h c=%b, required all 0", busy, done, s, c);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %b, required 0", ovf);
      end
`endif
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tc, input bit disturb);
      int lat;
      bit moved, blow;
      logic [W:0] exp;
      exp = ref_sum(ta, tb_, tc);
      run_op(ta, tb_, tc, disturb, lat, moved, blow);
      n_checks++;
      if (lat != int'(W)) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, W);
      end
      n_checks++;
      if ({c, s} !== exp) begin
         n_fail++;
         $display("FAIL %s_result: got c=%b s=%h, required c=%b s=%h", name, c, s, exp[W], exp[W-1:0]);
      end
      n_checks++;
      if (moved || blow) begin
         n_fail++;
         $display("FAIL %s_run_visibility: s_changed_early=%b busy_dropped=%b, required 0/0", name, moved, blow);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (ovf !== ref_ovf(ta, tb_, tc)) begin
         n_fail++;
         $display("FAIL %s_ovf: got %b, required %b", name, ovf, ref_ovf(ta, tb_, tc));
      end
`endif
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_width: done=%b busy=%b one edge later, required 0/0", name, done, busy);
      end
   endtask

   task automatic test_directed();
      check_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 0);
      check_op("7f_plus_01", 8'h7F, 8'h01, 1'b0, 0);
      check_op("cin_only", 8'h00, 8'h00, 1'b1, 0);
   endtask

   task automatic test_ignore_start();
      int extra;
      check_op("disturbed", 8'h00, 8'h00, 1'b1, 1);
      extra = 0;
      for (int k = 0; k < int'(W) + 4; k++) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL disturbed_extra_done: got %0d pulses, required 0", extra);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic rc;
      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         check_op("random", ra, rb, rc, 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pa[3];
      logic [W-1:0] pb[3];
      int done_at[$];
      logic [W:0] got[$];
      logic [W:0] exp;
      pa[0] = 8'h12; pb[0] = 8'h34;
      pa[1] = 8'hA5; pb[1] = 8'h5A;
      pa[2] = 8'h80; pb[2] = 8'h80;
      a = pa[0]; b = pb[0]; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = pa[1]; b = pb[1];
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 10) begin a = pa[2]; b = pb[2]; end
         if (k == 20) start = 1'b0;
         if (done) begin
            done_at.push_back(k);
            got.push_back({c, s});
         end
      end
      n_checks++;
      if (done_at.size() != 3) begin
         n_fail++;
         $display("FAIL b2b_done_count: got %0d, required 3", done_at.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            exp = ref_sum(pa[i], pb[i], 1'b0);
            n_checks++;
            if (done_at[i] != int'(W) + i * int'(W + 2)) begin
               n_fail++;
               $display("FAIL b2b_timing%0d: done at edge %0d, required %0d", i, done_at[i], int'(W) + i * int'(W + 2));
            end
            n_checks++;
            if (got[i] !== exp) begin
               n_fail++;
               $display("FAIL b2b_result%0d: got {c,s}=%h, required %h", i, got[i], exp);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      int pulses;
      check_op("pre_reset", 8'h55, 8'h22, 1'b0, 0);
      a = 8'hA0; b = 8'hB3; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, s, c} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b done=%b s=%h c=%b, required all 0", busy, done, s, c);
      end
      pulses = 0;
      for (int k = 0; k < int'(W) + 2; k++) begin
         @(posedge clk); #1;
         if (done) pulses++;
         if (k == 2) begin #2 rst = 1'b0; end
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL async_reset_no_done: got %0d pulses, required 0", pulses);
      end
      check_op("after_reset", 8'h03, 8'h04, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_random();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
